// File: rtl/stage_if_if.sv
// Instruction-memory bus between the fetch stage and instruction memory.
//   imem_addr  : word-aligned fetch address (master -> slave)
//   imem_req   : fetch request, address stable until ack (master -> slave)
//   imem_ack   : fetch complete, imem_rdata valid this cycle (slave -> master)
//   imem_rdata : fetched word (slave -> master)
interface stage_if_if;
  logic [31:0] imem_addr;
  logic        imem_req;
  logic        imem_ack;
  logic [31:0] imem_rdata;

  modport master (
    output imem_addr,
    output imem_req,
    input  imem_ack,
    input  imem_rdata
  );

  modport slave (
    input  imem_addr,
    input  imem_req,
    output imem_ack,
    output imem_rdata
  );
endinterface

// File: rtl/stage_if.sv
// Instruction-fetch stage. Owns the PC, fetches words over the imem req/ack
// bus and presents {next_pc, instr} to decode through a registered IF->ID
// interstage. Buffers a fetched word across decode stalls and redirects on
// taken branches, draining a fetch that is already in flight.
//   clk              : rising-edge clock
//   rst              : asynchronous active-low reset
//   stall            : decode cannot accept; hold the interstage output
//   branch_taken     : single-cycle redirect request from execute
//   branch_dest      : redirect target, bits[1:0] ignored
//   imem             : instruction-memory bus (master side)
//   interstage_if2id : {next_pc[63:32], instr[31:0]}, registered
//   debug_pc         : current PC
module stage_if #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                stall,
  input  logic                branch_taken,
  input  logic [31:0]         branch_dest,
  stage_if_if.master          imem,
  output logic [63:0]         interstage_if2id,
  output logic [31:0]         debug_pc
);

  localparam int unsigned XLEN             = 32;
  localparam int unsigned IF2ID_WIRE_WIDTH = 2 * XLEN;

  typedef enum logic [1:0] {
    ST_FETCH   = 2'd0,
    ST_STALLED = 2'd1,
    ST_DRAIN   = 2'd2
  } state_e;

  state_e                      state_q, state_d;
  logic [XLEN-1:0]             pc_q, pc_d;
  logic                        started_q;
  logic [IF2ID_WIRE_WIDTH-1:0] out_q, out_d;
  logic [XLEN-1:0]             hold_q, hold_d;
  logic [XLEN-1:0]             pending_q, pending_d;
  logic [XLEN-1:0]             pending_old_q, pending_old_d;

  logic                        req_c;
  logic                        ack_c;
  logic [XLEN-1:0]             dest_c;
  logic [XLEN-1:0]             pc_plus4_c;
  logic [IF2ID_WIRE_WIDTH-1:0] bubble_c;

  // State registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= ST_FETCH;
      pc_q          <= RESET_PC;
      started_q     <= 1'b0;
      out_q         <= {RESET_PC + 32'd4, NOP_INSTR};
      hold_q        <= '0;
      pending_q     <= '0;
      pending_old_q <= '0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      started_q     <= 1'b1;
      out_q         <= out_d;
      hold_q        <= hold_d;
      pending_q     <= pending_d;
      pending_old_q <= pending_old_d;
    end
  end

  // Next-state and datapath. Priority is redirect > ack > stall.
  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    out_d         = out_q;
    hold_d        = hold_q;
    pending_d     = pending_q;
    pending_old_d = pending_old_q;

    req_c      = started_q && (state_q == ST_FETCH || state_q == ST_DRAIN);
    // An ack without a live request (e.g. left over from before reset) is ignored.
    ack_c      = imem.imem_ack && req_c;
    dest_c     = {branch_dest[XLEN-1:2], 2'b00};
    pc_plus4_c = pc_q + 32'd4;
    bubble_c   = {pc_plus4_c, NOP_INSTR};

    unique case (state_q)
      ST_FETCH: begin
        if (branch_taken) begin
          out_d = bubble_c;
          if (ack_c) begin
            pc_d = dest_c;
          end else begin
            // Fetch in flight cannot be aborted: wait for its ack, then redirect.
            pending_d     = dest_c;
            pending_old_d = pc_q;
            state_d       = ST_DRAIN;
          end
        end else if (ack_c) begin
          if (stall) begin
            hold_d  = imem.imem_rdata;
            state_d = ST_STALLED;
          end else begin
            out_d = {pc_plus4_c, imem.imem_rdata};
            pc_d  = pc_plus4_c;
          end
        end else if (!stall) begin
          out_d = bubble_c;
        end
      end

      ST_STALLED: begin
        if (branch_taken) begin
          pc_d    = dest_c;
          out_d   = bubble_c;
          state_d = ST_FETCH;
        end else if (!stall) begin
          out_d   = {pc_plus4_c, hold_q};
          pc_d    = pc_plus4_c;
          state_d = ST_FETCH;
        end
      end

      ST_DRAIN: begin
        out_d = bubble_c;
        // Latest redirect wins, including one coinciding with the draining ack.
        if (branch_taken) begin
          pending_d = dest_c;
        end
        if (ack_c) begin
          pc_d    = branch_taken ? dest_c : pending_q;
          state_d = ST_FETCH;
        end
      end

      default: begin
        state_d = ST_FETCH;
      end
    endcase
  end

  // Bus and observation outputs, decoded directly from registered state.
  assign imem.imem_req    = req_c;
  assign imem.imem_addr   = (state_q == ST_DRAIN) ? pending_old_q : pc_q;
  assign interstage_if2id = out_q;
  assign debug_pc         = pc_q;

endmodule

// File: tb/tb_stage_if.sv
// Self-checking bench for stage_if: directed scenarios with literal
// expectations, then randomized stall/redirect/wait-state/reset traffic
// compared every cycle against a behavioural fetch model.
module tb_stage_if;

  logic        clk;
  logic        rst;
  logic        stall;
  logic        branch_taken;
  logic [31:0] branch_dest;
  logic [63:0] if2id;
  logic [31:0] debug_pc;
  logic [63:0] if2id_w;
  logic [31:0] debug_pc_w;

  stage_if_if bus ();
  stage_if_if bus_w ();

  stage_if u_dut (
    .clk              (clk),
    .rst              (rst),
    .stall            (stall),
    .branch_taken     (branch_taken),
    .branch_dest      (branch_dest),
    .imem             (bus),
    .interstage_if2id (if2id),
    .debug_pc         (debug_pc)
  );

  // Second instance starting at the top of the address space, zero-wait memory.
  stage_if #(.RESET_PC(32'hFFFF_FFFC)) u_wrap (
    .clk              (clk),
    .rst              (rst),
    .stall            (1'b0),
    .branch_taken     (1'b0),
    .branch_dest      (32'h0),
    .imem             (bus_w),
    .interstage_if2id (if2id_w),
    .debug_pc         (debug_pc_w)
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'hC0DE_0003;
  endfunction

  assign bus_w.imem_ack   = bus_w.imem_req;
  assign bus_w.imem_rdata = mem_word(bus_w.imem_addr);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks;
  int failures;

  // Behavioural model: architectural PC, a buffered word waiting out a stall,
  // and a discarded in-flight fetch with its redirect target.
  logic [31:0] m_pc;
  logic        m_started;
  logic        m_held;
  logic [31:0] m_hword;
  logic        m_disc;
  logic [31:0] m_tgt;
  logic [63:0] m_out;

  // Memory responder state.
  logic        mem_busy;
  int          mem_wl;
  int          minw;
  int          maxw;
  logic        spur;
  logic        force_spur;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_pc      = 32'h0;
    m_started = 1'b0;
    m_held    = 1'b0;
    m_hword   = 32'h0;
    m_disc    = 1'b0;
    m_tgt     = 32'h0;
    m_out     = {32'h4, 32'h0};
    mem_busy  = 1'b0;
  endtask

  // Drive one cycle of inputs at the negedge, advance the model across the
  // following posedge, then compare at the next negedge.
  task automatic tick(input logic br, input logic [31:0] dest, input logic stl, input logic rst_v);
    logic        ereq;
    logic        ack_d;
    logic        ack_eff;
    logic [31:0] rd;
    logic [31:0] d;
    logic [31:0] pc4;
    rst   = rst_v;
    stall = stl;
    if (!rst_v) begin
      model_reset();
      branch_taken     = 1'b0;
      branch_dest      = 32'h0;
      bus.imem_ack     = 1'b0;
      bus.imem_rdata   = 32'h0;
    end else begin
      ereq  = m_started && !m_held;
      ack_d = 1'b0;
      rd    = $urandom;
      if (ereq) begin
        if (!mem_busy) begin
          mem_busy = 1'b1;
          mem_wl   = int'($urandom_range(maxw, minw));
        end
        if (mem_wl == 0) begin
          ack_d    = 1'b1;
          rd       = mem_word(m_pc);
          mem_busy = 1'b0;
        end else begin
          mem_wl--;
        end
      end else if (force_spur || (spur && ($urandom % 4 == 0))) begin
        ack_d = 1'b1;
        rd    = 32'hDEAD_BEEF;
      end
      branch_taken   = br;
      branch_dest    = dest;
      bus.imem_ack   = ack_d;
      bus.imem_rdata = rd;

      ack_eff = ack_d && ereq;
      d       = {dest[31:2], 2'b00};
      pc4     = m_pc + 32'd4;
      if (m_disc) begin
        m_out = {pc4, 32'h0};
        if (br) m_tgt = d;
        if (ack_eff) begin
          m_pc   = m_tgt;
          m_disc = 1'b0;
        end
      end else if (m_held) begin
        if (br) begin
          m_out  = {pc4, 32'h0};
          m_pc   = d;
          m_held = 1'b0;
        end else if (!stl) begin
          m_out  = {pc4, m_hword};
          m_pc   = pc4;
          m_held = 1'b0;
        end
      end else begin
        if (br) begin
          m_out = {pc4, 32'h0};
          if (ack_eff) m_pc = d;
          else begin
            m_disc = 1'b1;
            m_tgt  = d;
          end
        end else if (ack_eff) begin
          if (stl) begin
            m_held  = 1'b1;
            m_hword = rd;
          end else begin
            m_out = {pc4, rd};
            m_pc  = pc4;
          end
        end else if (!stl) begin
          m_out = {pc4, 32'h0};
        end
      end
      m_started = 1'b1;
    end
    @(negedge clk);
    ereq = m_started && !m_held;
    chk("if2id", if2id, m_out);
    chk("imem_req", 64'(bus.imem_req), 64'(ereq));
    if (ereq) chk("imem_addr", 64'(bus.imem_addr), 64'(m_pc));
    chk("debug_pc", 64'(debug_pc), 64'(m_pc));
  endtask

  initial begin
    logic        r_br;
    logic        r_st;
    logic        r_rst;
    logic [31:0] r_dest;
    checks       = 0;
    failures     = 0;
    rst          = 1'b0;
    stall        = 1'b0;
    branch_taken = 1'b0;
    branch_dest  = 32'h0;
    bus.imem_ack   = 1'b0;
    bus.imem_rdata = 32'h0;
    minw       = 0;
    maxw       = 0;
    spur       = 1'b0;
    force_spur = 1'b0;
    mem_wl     = 0;
    model_reset();

    // Reset state.
    tick(1'b0, 32'h0, 1'b0, 1'b0);
    tick(1'b0, 32'h0, 1'b0, 1'b0);
    chk("rst_out", if2id, {32'h4, 32'h0});
    chk("rst_req", 64'(bus.imem_req), 64'h0);
    chk("rst_pc", 64'(debug_pc), 64'h0);
    chk("wrap_rst_out", if2id_w, {32'h0, 32'h0});

    // Release with zero-wait memory.
    tick(1'b0, 32'h0, 1'b0, 1'b1);
    chk("start_out", if2id, {32'h4, 32'h0});
    chk("start_addr", 64'(bus.imem_addr), 64'h0);
    chk("wrap_addr0", 64'(bus_w.imem_addr), 64'hFFFF_FFFC);
    tick(1'b0, 32'h0, 1'b0, 1'b1);
    chk("zw_i0", if2id, {32'h4, 32'hC0DE_0003});
    chk("wrap_out", if2id_w, {32'h0, 32'h3F21_FFFF});
    chk("wrap_addr1", 64'(bus_w.imem_addr), 64'h0);
    tick(1'b0, 32'h0, 1'b0, 1'b1);
    chk("zw_i1", if2id, {32'h8, 32'hC0DE_0007});
    tick(1'b0, 32'h0, 1'b0, 1'b1);
    chk("zw_i2", if2id, {32'hC, 32'hC0DE_000B});
    chk("zw_addr", 64'(bus.imem_addr), 64'hC);

    // Stall raised on the ack of 0xC for three cycles.
    for (int i = 0; i < 3; i++) begin
      tick(1'b0, 32'h0, 1'b1, 1'b1);
      chk("stall_hold", if2id, {32'hC, 32'hC0DE_000B});
      chk("stall_req", 64'(bus.imem_req), 64'h0);
    end
    tick(1'b0, 32'h0, 1'b0, 1'b1);
    chk("stall_rel", if2id, {32'h10, 32'hC0DE_000F});

    // Redirect to 0x100 (low bits set, must be ignored) while 0x10 is in flight.
    minw = 2;
    maxw = 2;
    tick(1'b1, 32'h0000_0103, 1'b0, 1'b1);
    chk("br_nop", if2id, {32'h14, 32'h0});
    chk("br_drain_addr", 64'(bus.imem_addr), 64'h10);
    tick(1'b0, 32'h0, 1'b0, 1'b1);
    tick(1'b0, 32'h0, 1'b0, 1'b1);
    chk("br_new_addr", 64'(bus.imem_addr), 64'h100);
    for (int i = 0; i < 3; i++) tick(1'b0, 32'h0, 1'b0, 1'b1);
    chk("br_target", if2id, {32'h104, 32'hC0DE_0103});

    // Two redirects while draining: the later one (0x200) wins.
    tick(1'b1, 32'h0000_0300, 1'b0, 1'b1);
    tick(1'b1, 32'h0000_0200, 1'b1, 1'b1);
    tick(1'b0, 32'h0, 1'b0, 1'b1);
    chk("drain_addr", 64'(bus.imem_addr), 64'h200);
    for (int i = 0; i < 3; i++) tick(1'b0, 32'h0, 1'b0, 1'b1);
    chk("drain_target", if2id, {32'h204, 32'hC0DE_0203});

    // Reset mid-fetch; a late ack right after release must be ignored.
    tick(1'b0, 32'h0, 1'b0, 1'b1);
    tick(1'b0, 32'h0, 1'b0, 1'b0);
    tick(1'b0, 32'h0, 1'b0, 1'b0);
    force_spur = 1'b1;
    tick(1'b0, 32'h0, 1'b0, 1'b1);
    force_spur = 1'b0;
    chk("late_ack_out", if2id, {32'h4, 32'h0});
    chk("late_ack_addr", 64'(bus.imem_addr), 64'h0);

    // Randomized traffic.
    minw = 0;
    maxw = 2;
    spur = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      r_st   = ($urandom % 10) < 3;
      r_br   = ($urandom % 12) == 0;
      r_dest = $urandom;
      r_rst  = ($urandom % 400) != 0;
      tick(r_br, r_dest, r_st, r_rst);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
